// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU M stage, DMA/loader),
// the arbiter and the single data_memory port. The arbiter uses the slave view;
// whatever drives the requests and models memory uses the master view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_valid;
  logic              dma_ready;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the CPU M stage and a DMA/loader.
// One access is granted per cycle; the CPU normally wins, but a DMA requester
// that keeps losing is forced through after STARVE_MAX consecutive losses.
// Read data returns one cycle after the read strobe and is steered back to the
// requester that issued the read. The reset input is active-low.
module dmem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input logic          clock,
  input logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_CPU,
    RESP_DMA
  } respStateT;

  respStateT         respState;
  respStateT         respNext;
  logic [CW-1:0]     starveCnt;
  logic [CW-1:0]     starveNext;
  logic              starveHit;
  logic              cpuGnt;
  logic              dmaGnt;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              cpuRvalid;
  logic              dmaRvalid;
  logic [DATA_W-1:0] cpuRdata;
  logic [DATA_W-1:0] dmaRdata;

  // Same-cycle grant: a lone requester wins, on contention the CPU wins unless
  // the DMA has been starved long enough; nothing is granted while in reset.
  always_comb begin
    starveHit = (starveCnt == STARVE_LIM);
    cpuGnt    = 1'b0;
    dmaGnt    = 1'b0;
    if (reset) begin
      cpuGnt = bus.cpu_req & (~bus.dma_valid | ~starveHit);
      dmaGnt = bus.dma_valid & (~bus.cpu_req | starveHit);
    end
  end

  // Drive the memory port from whichever requester holds the grant, else idle.
  always_comb begin
    memRead  = 1'b0;
    memWrite = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    if (cpuGnt) begin
      memRead  = ~bus.cpu_we;
      memWrite = bus.cpu_we;
      memAddr  = bus.cpu_addr;
      memWdata = bus.cpu_wdata;
    end else if (dmaGnt) begin
      memRead  = ~bus.dma_we;
      memWrite = bus.dma_we;
      memAddr  = bus.dma_addr;
      memWdata = bus.dma_wdata;
    end
  end

  // Count consecutive DMA losses, saturating; any DMA grant or idle cycle restarts it.
  always_comb begin
    starveNext = starveCnt;
    if (!bus.dma_valid || dmaGnt) begin
      starveNext = '0;
    end else if (starveCnt != STARVE_LIM) begin
      starveNext = starveCnt + CW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else begin
      starveCnt <= starveNext;
    end
  end

  // Response owner register: remembers who issued this cycle's read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      respState <= RESP_IDLE;
    end else begin
      respState <= respNext;
    end
  end

  // Next owner plus steering of the returning read data to that owner only.
  always_comb begin
    respNext  = RESP_IDLE;
    cpuRvalid = 1'b0;
    dmaRvalid = 1'b0;
    cpuRdata  = '0;
    dmaRdata  = '0;
    if (cpuGnt && !bus.cpu_we) begin
      respNext = RESP_CPU;
    end else if (dmaGnt && !bus.dma_we) begin
      respNext = RESP_DMA;
    end
    case (respState)
      RESP_CPU: begin
        cpuRvalid = 1'b1;
        cpuRdata  = bus.mem_rdata;
      end
      RESP_DMA: begin
        dmaRvalid = 1'b1;
        dmaRdata  = bus.mem_rdata;
      end
      default: begin
        cpuRvalid = 1'b0;
        dmaRvalid = 1'b0;
      end
    endcase
  end

  assign bus.cpu_stall  = bus.cpu_req & ~cpuGnt;
  assign bus.dma_ready  = dmaGnt;
  assign bus.mem_read   = memRead;
  assign bus.mem_write  = memWrite;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;
  assign bus.cpu_rvalid = cpuRvalid;
  assign bus.cpu_rdata  = cpuRdata;
  assign bus.dma_rvalid = dmaRvalid;
  assign bus.dma_rdata  = dmaRdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change 1 time unit after a rising
// edge and outputs are sampled 1 time unit later, well away from the edge.
module tb_dmem_arbiter;

  logic clock;
  logic reset;
  int   assertCount;
  int   failCount;

  dmem_arbiter_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .STARVE_MAX(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // 10-unit clock period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_valid = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset         = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.dma_valid = 1'b1;
    bus.mem_rdata = 64'hFF;
    tick();
    tick();
    #1;
    assertCount++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL resetMem: read=%b write=%b expected 0 0", bus.mem_read, bus.mem_write);
    end
    assertCount++;
    if (bus.dma_ready !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL resetGrant: dma_ready=%b cpu_stall=%b expected 0 1", bus.dma_ready, bus.cpu_stall);
    end
    assertCount++;
    if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.cpu_rdata !== 64'h0 || bus.dma_rdata !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL resetResp: cpu %b/%h dma %b/%h expected all 0", bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata);
    end
    idleInputs();
    reset = 1'b1;
  endtask

  task automatic test_cpu_load();
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 64'h100;
    #1;
    assertCount++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 64'h100 || bus.cpu_stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cpuLoadIssue: read=%b write=%b addr=%h stall=%b expected 1 0 100 0", bus.mem_read, bus.mem_write, bus.mem_addr, bus.cpu_stall);
    end
    tick();
    idleInputs();
    bus.mem_rdata = 64'hA5;
    #1;
    assertCount++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 64'hA5 || bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL cpuLoadResp: cpu %b/%h dma %b/%h expected 1/a5 0/0", bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata);
    end
    tick();
    #1;
    assertCount++;
    if (bus.cpu_rvalid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cpuLoadOnce: cpu_rvalid=%b expected 0", bus.cpu_rvalid);
    end
  endtask

  task automatic test_dma_write();
    tick();
    bus.dma_valid = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 64'h40;
    bus.dma_wdata = 64'hDEADBEEF;
    #1;
    assertCount++;
    if (bus.dma_ready !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 64'h40 || bus.mem_wdata !== 64'hDEADBEEF) begin
      failCount++;
      $display("[TB] FAIL dmaWrite: ready=%b write=%b read=%b addr=%h wdata=%h expected 1 1 0 40 deadbeef", bus.dma_ready, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    idleInputs();
    bus.mem_rdata = 64'h77;
    #1;
    assertCount++;
    if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL dmaWriteNoResp: cpu_rvalid=%b dma_rvalid=%b expected 0 0", bus.cpu_rvalid, bus.dma_rvalid);
    end
  endtask

  task automatic test_starvation();
    tick();
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 64'h200;
    bus.dma_valid = 1'b1;
    bus.dma_addr  = 64'h300;
    for (int i = 0; i < 10; i++) begin
      logic expDma;
      logic [63:0] expAddr;
      expDma  = ((i % 5) == 4);
      expAddr = expDma ? 64'h300 : 64'h200;
      #1;
      assertCount++;
      if (bus.dma_ready !== expDma || bus.cpu_stall !== expDma || bus.mem_addr !== expAddr) begin
        failCount++;
        $display("[TB] FAIL starve cycle %0d: dma_ready=%b cpu_stall=%b addr=%h expected %b %b %h", i, bus.dma_ready, bus.cpu_stall, bus.mem_addr, expDma, expDma, expAddr);
      end
      assertCount++;
      if (dut.starveCnt !== 3'(i % 5)) begin
        failCount++;
        $display("[TB] FAIL starveCnt cycle %0d: got %0d expected %0d", i, dut.starveCnt, i % 5);
      end
      tick();
    end
    idleInputs();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic expCpuV;
      logic expDmaV;
      logic [63:0] expAddr;
      idleInputs();
      if ((i % 2) == 0) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 64'h8;
        expAddr      = 64'h8;
      end else begin
        bus.dma_valid = 1'b1;
        bus.dma_addr  = 64'h10;
        expAddr       = 64'h10;
      end
      bus.mem_rdata = 64'h1000 + 64'(i);
      expCpuV = ((i % 2) == 1);
      expDmaV = ((i % 2) == 0) && (i > 0);
      #1;
      assertCount++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== expAddr) begin
        failCount++;
        $display("[TB] FAIL altIssue %0d: read=%b addr=%h expected 1 %h", i, bus.mem_read, bus.mem_addr, expAddr);
      end
      assertCount++;
      if (bus.cpu_rvalid !== expCpuV || bus.dma_rvalid !== expDmaV ||
          bus.cpu_rdata !== (expCpuV ? 64'h1000 + 64'(i) : 64'h0) ||
          bus.dma_rdata !== (expDmaV ? 64'h1000 + 64'(i) : 64'h0)) begin
        failCount++;
        $display("[TB] FAIL altResp %0d: cpu %b/%h dma %b/%h expected cpu %b dma %b data %h", i, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata, expCpuV, expDmaV, 64'h1000 + 64'(i));
      end
      tick();
    end
    idleInputs();
    bus.mem_rdata = 64'h2000;
    #1;
    assertCount++;
    if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 64'h2000 || bus.cpu_rvalid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL altLast: dma %b/%h cpu_rvalid=%b expected 1/2000 0", bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid);
    end
  endtask

  task automatic test_reset_drop();
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 64'h100;
    #1;
    assertCount++;
    if (bus.mem_read !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL dropIssue: read=%b expected 1", bus.mem_read);
    end
    tick();
    idleInputs();
    reset         = 1'b0;
    bus.mem_rdata = 64'h5A;
    #1;
    assertCount++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 64'h0 || dut.starveCnt !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL dropResp: cpu %b/%h starveCnt=%0d expected 0/0 0", bus.cpu_rvalid, bus.cpu_rdata, dut.starveCnt);
    end
    tick();
    reset        = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 64'h18;
    #1;
    assertCount++;
    if (bus.mem_read !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.mem_addr !== 64'h18) begin
      failCount++;
      $display("[TB] FAIL afterResetIssue: read=%b stall=%b addr=%h expected 1 0 18", bus.mem_read, bus.cpu_stall, bus.mem_addr);
    end
    tick();
    idleInputs();
    bus.mem_rdata = 64'h33;
    #1;
    assertCount++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 64'h33) begin
      failCount++;
      $display("[TB] FAIL afterResetResp: cpu %b/%h expected 1/33", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_starve_restart();
    tick();
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 64'h400;
    bus.dma_valid = 1'b1;
    bus.dma_addr  = 64'h500;
    for (int i = 0; i < 3; i++) begin
      #1;
      assertCount++;
      if (bus.dma_ready !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL restartLose %0d: dma_ready=%b expected 0", i, bus.dma_ready);
      end
      tick();
    end
    bus.dma_valid = 1'b0;
    #1;
    assertCount++;
    if (bus.dma_ready !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL restartGap: dma_ready=%b cpu_stall=%b expected 0 0", bus.dma_ready, bus.cpu_stall);
    end
    tick();
    bus.dma_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic expDma;
      expDma = (i == 4);
      #1;
      assertCount++;
      if (bus.dma_ready !== expDma || bus.cpu_stall !== expDma) begin
        failCount++;
        $display("[TB] FAIL restartCount %0d: dma_ready=%b cpu_stall=%b expected %b %b", i, bus.dma_ready, bus.cpu_stall, expDma, expDma);
      end
      tick();
    end
    idleInputs();
  endtask

  // Run every scenario in order and report once.
  initial begin
    assertCount = 0;
    failCount   = 0;
    test_reset();
    test_cpu_load();
    test_dma_write();
    test_starvation();
    test_back_to_back();
    test_reset_drop();
    test_starve_restart();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
